// File: rtl/exc_controller.sv
// Exception/interrupt controller for the LEGv8 single-cycle core: owns ELR, ESR and handler mode.
// Optional macro EXC_IRQ_SYNC_EN adds a 2-flop synchronizer ahead of the IRQ sample register.
module exc_controller #(
  parameter int           N          = 64,
  parameter logic [N-1:0] EXC_VECTOR = 64'h0000_0000_0000_00D8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ExtIRQ,
  input  logic         NotAnInstr,
  input  logic         ERet,
  input  logic         ExcAck,
  input  logic [N-1:0] PC_cur,
  output logic         Exc,
  output logic [N-1:0] VecPC,
  output logic         ERetTaken,
  output logic [N-1:0] ELR,
  output logic [3:0]   EStatus,
  output logic         InHandler,
  output logic         ExtlAck,
  output logic         DoubleFault
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2
  } state_t;

  localparam logic [3:0] CAUSE_IRQ   = 4'b0001;
  localparam logic [3:0] CAUSE_UNDEF = 4'b0010;

  state_t state_r;
  logic   ack_done_r;
  logic   irq_r;
  logic   irq_s;

`ifdef EXC_IRQ_SYNC_EN
  logic sync1_r;
  logic sync2_r;

  // Two-stage synchronizer for the asynchronous request, followed by the sample register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      irq_r   <= 1'b0;
    end else begin
      sync1_r <= ExtIRQ;
      sync2_r <= sync1_r;
      irq_r   <= sync2_r;
    end
  end
`else
  // Single sample register for the request level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= ExtIRQ;
    end
  end
`endif

  assign irq_s = irq_r;
  assign VecPC = EXC_VECTOR;

  // Exception FSM; every output except VecPC is a register updated here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      ELR         <= '0;
      EStatus     <= 4'b0000;
      Exc         <= 1'b0;
      ERetTaken   <= 1'b0;
      ExtlAck     <= 1'b0;
      InHandler   <= 1'b0;
      DoubleFault <= 1'b0;
      ack_done_r  <= 1'b0;
    end else begin
      Exc       <= 1'b0;
      ERetTaken <= 1'b0;
      ExtlAck   <= 1'b0;
      case (state_r)
        IDLE: begin
          // IRQ wins over an undefined opcode in the same cycle.
          if (irq_s) begin
            state_r    <= TAKE;
            Exc        <= 1'b1;
            ELR        <= PC_cur;
            EStatus    <= CAUSE_IRQ;
            ack_done_r <= 1'b0;
          end else if (NotAnInstr) begin
            state_r    <= TAKE;
            Exc        <= 1'b1;
            ELR        <= PC_cur;
            EStatus    <= CAUSE_UNDEF;
            ack_done_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        TAKE: begin
          state_r   <= HANDLER;
          InHandler <= 1'b1;
        end
        HANDLER: begin
          if (NotAnInstr) begin
            DoubleFault <= 1'b1;
          end else begin
            DoubleFault <= DoubleFault;
          end
          if (ExcAck && (EStatus == CAUSE_IRQ) && !ack_done_r) begin
            ExtlAck    <= 1'b1;
            ack_done_r <= 1'b1;
          end else begin
            ack_done_r <= ack_done_r;
          end
          if (ERet) begin
            ERetTaken <= 1'b1;
            InHandler <= 1'b0;
            state_r   <= IDLE;
          end else begin
            state_r <= HANDLER;
          end
        end
        default: begin
          state_r   <= IDLE;
          InHandler <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exc_controller.sv
// Directed self-checking bench for exc_controller; inputs change and outputs are sampled on negedge.
module tb_exc_controller;

`ifdef EXC_IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        reset;
  logic        ExtIRQ;
  logic        NotAnInstr;
  logic        ERet;
  logic        ExcAck;
  logic [63:0] PC_cur;
  logic        Exc;
  logic [63:0] VecPC;
  logic        ERetTaken;
  logic [63:0] ELR;
  logic [3:0]  EStatus;
  logic        InHandler;
  logic        ExtlAck;
  logic        DoubleFault;

  int checks   = 0;
  int failures = 0;
  int acks     = 0;

  exc_controller #(.N(64), .EXC_VECTOR(64'h0000_0000_0000_00D8)) dut (
    .clk(clk), .reset(reset), .ExtIRQ(ExtIRQ), .NotAnInstr(NotAnInstr),
    .ERet(ERet), .ExcAck(ExcAck), .PC_cur(PC_cur), .Exc(Exc), .VecPC(VecPC),
    .ERetTaken(ERetTaken), .ELR(ELR), .EStatus(EStatus), .InHandler(InHandler),
    .ExtlAck(ExtlAck), .DoubleFault(DoubleFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; ExtIRQ = 1'b0; NotAnInstr = 1'b0; ERet = 1'b0; ExcAck = 1'b0;
    PC_cur = 64'h0;
    step(); step();
    chk("rst_exc", {63'd0, Exc}, 64'd0);
    chk("rst_elr", ELR, 64'd0);
    chk("rst_esr", {60'd0, EStatus}, 64'd0);
    chk("rst_inh", {63'd0, InHandler}, 64'd0);
    chk("rst_df", {63'd0, DoubleFault}, 64'd0);
    chk("rst_ack", {63'd0, ExtlAck}, 64'd0);
    chk("vecpc", VecPC, 64'h0000_0000_0000_00D8);
    reset = 1'b0;
    step();

    // Undefined opcode entry and return
    NotAnInstr = 1'b1; PC_cur = 64'h40;
    step();
    NotAnInstr = 1'b0; PC_cur = 64'h44;
    chk("ud_exc", {63'd0, Exc}, 64'd1);
    chk("ud_elr", ELR, 64'h40);
    chk("ud_esr", {60'd0, EStatus}, 64'd2);
    step();
    chk("ud_exc_off", {63'd0, Exc}, 64'd0);
    chk("ud_inh", {63'd1 & 63'd0, InHandler}, 64'd1);
    step(); step();
    ERet = 1'b1;
    step();
    ERet = 1'b0;
    chk("ud_eret", {63'd0, ERetTaken}, 64'd1);
    chk("ud_inh_off", {63'd0, InHandler}, 64'd0);
    chk("ud_elr_hold", ELR, 64'h40);
    step();
    chk("ud_eret_off", {63'd0, ERetTaken}, 64'd0);
    ERet = 1'b1;
    step();
    ERet = 1'b0;
    chk("idle_eret_ign", {63'd0, ERetTaken}, 64'd0);
    chk("idle_eret_noexc", {63'd0, Exc}, 64'd0);

    // IRQ entry, latency and single acknowledge
    ExtIRQ = 1'b1; PC_cur = 64'h100;
    for (int i = 0; i < LAT - 1; i++) begin
      step();
      chk("irq_lat_noexc", {63'd0, Exc}, 64'd0);
    end
    step();
    chk("irq_exc", {63'd0, Exc}, 64'd1);
    chk("irq_esr", {60'd0, EStatus}, 64'd1);
    chk("irq_elr", ELR, 64'h100);
    step();
    chk("irq_inh", {63'd0, InHandler}, 64'd1);
    ExcAck = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      acks += int'(ExtlAck);
    end
    ExcAck = 1'b0;
    chk("irq_one_ack", 64'(acks), 64'd1);

    // Return with IRQ still high re-takes it after one IDLE cycle
    ERet = 1'b1;
    step();
    ERet = 1'b0;
    chk("retake_eret", {63'd0, ERetTaken}, 64'd1);
    chk("retake_gap", {63'd0, Exc}, 64'd0);
    step();
    chk("retake_exc", {63'd0, Exc}, 64'd1);
    chk("retake_esr", {60'd0, EStatus}, 64'd1);
    ExtIRQ = 1'b0;
    step();
    ExcAck = 1'b1;
    step();
    ExcAck = 1'b0;
    chk("retake_ack_rearmed", {63'd0, ExtlAck}, 64'd1);
    ERet = 1'b1;
    step();
    ERet = 1'b0;
    step();
    chk("no_spurious_exc", {63'd0, Exc}, 64'd0);

    // Priority, masking and double fault
    ExtIRQ = 1'b1; PC_cur = 64'h80;
    for (int i = 0; i < LAT - 1; i++) step();
    NotAnInstr = 1'b1;
    step();
    chk("prio_exc", {63'd0, Exc}, 64'd1);
    chk("prio_esr", {60'd0, EStatus}, 64'd1);
    ExtIRQ = 1'b0;
    step();
    chk("mask_df_take", {63'd0, DoubleFault}, 64'd0);
    step();
    NotAnInstr = 1'b0;
    chk("mask_noexc", {63'd0, Exc}, 64'd0);
    chk("mask_df", {63'd0, DoubleFault}, 64'd1);

    // ERet and ExcAck together
    ERet = 1'b1; ExcAck = 1'b1;
    step();
    ERet = 1'b0; ExcAck = 1'b0;
    chk("sim_ack", {63'd0, ExtlAck}, 64'd1);
    chk("sim_eret", {63'd0, ERetTaken}, 64'd1);
    chk("sim_inh_off", {63'd0, InHandler}, 64'd0);
    step();
    chk("sim_ack_off", {63'd0, ExtlAck}, 64'd0);
    chk("sim_idle_noexc", {63'd0, Exc}, 64'd0);
    chk("df_sticky", {63'd0, DoubleFault}, 64'd1);

    // Async reset in HANDLER without a clock edge
    NotAnInstr = 1'b1; PC_cur = 64'h200;
    step();
    NotAnInstr = 1'b0;
    step();
    chk("ar_inh_pre", {63'd0, InHandler}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_inh", {63'd0, InHandler}, 64'd0);
    chk("ar_elr", ELR, 64'd0);
    chk("ar_esr", {60'd0, EStatus}, 64'd0);
    chk("ar_df", {63'd0, DoubleFault}, 64'd0);
    step();
    reset = 1'b0;
    step();
    chk("ar_idle_exc", {63'd0, Exc}, 64'd0);
    NotAnInstr = 1'b1; PC_cur = 64'h300;
    step();
    NotAnInstr = 1'b0;
    chk("ar_idle_take", {63'd0, Exc}, 64'd1);
    chk("ar_idle_elr", ELR, 64'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
